branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue_pkg.sv | 36 +++
 rtl/branch_resolve_queue_storage.sv | 32 +++
 rtl/branch_resolve_queue.sv | 123 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_resolve_queue_pkg                                                 |
// | Fetch-stage shared defaults, entry record layout and helper functions.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package branch_resolve_queue_pkg;

    localparam int c_bq_depth = 4;
    localparam int c_bq_idx_w = 5;

    // Packed layout of one in-flight branch.
    // The queue stores this same field order as a flat vector.
    typedef struct packed {
        logic [31:0]           pc;
        logic [c_bq_idx_w-1:0] idx;
        logic                  taken;
        logic [31:0]           target;
    } bq_entry_t;

    function automatic int bq_entry_w(input int idx_w);
        return 32 + idx_w + 1 + 32;
    endfunction

    // The target only matters when both the prediction and the outcome are taken.
    function automatic logic bq_mispredict(
        input logic        st_taken,
        input logic [31:0] st_target,
        input logic        res_taken,
        input logic [31:0] res_target
    );
        return (st_taken != res_taken) || (st_taken && res_taken && (st_target != res_target));
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_queue_storage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_resolve_queue_storage                                             |
// | DEPTH-entry register array, one write port, one async read port.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module branch_resolve_queue_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 70,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [PTR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [PTR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are qualified by the owner's count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_resolve_queue                                                     |
// | FIFO of predicted branches; emits predictor updates and redirects.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = c_bq_depth,
    parameter int IDX_W = c_bq_idx_w
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [31:0]      push_pc_i,
    input  logic [IDX_W-1:0] push_idx_i,
    input  logic             push_taken_i,
    input  logic [31:0]      push_target_i,
    input  logic             res_valid_i,
    input  logic             res_taken_i,
    input  logic [31:0]      res_target_i,
    output logic             upd_valid_o,
    output logic [IDX_W-1:0] upd_idx_o,
    output logic             upd_taken_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             res_err_o
);

    localparam int               c_ptr_w   = $clog2(DEPTH);
    localparam int               c_entry_w = bq_entry_w(IDX_W);
    localparam logic [c_ptr_w:0] c_full    = (c_ptr_w + 1)'(DEPTH);

    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic                 w_do_push;
    logic                 w_do_res;
    logic                 w_mispredict;
    logic [c_entry_w-1:0] w_push_data;
    logic [c_entry_w-1:0] w_head;
    logic [31:0]          w_head_pc;
    logic [IDX_W-1:0]     w_head_idx;
    logic                 w_head_taken;
    logic [31:0]          w_head_target;

    // No bypass: a full queue refuses pushes even while the head resolves.
    assign push_ready_o = (r_count != c_full);
    assign w_do_push    = push_valid_i && push_ready_o;
    assign w_do_res     = res_valid_i && (r_count != '0);

    assign w_push_data = {push_pc_i, push_idx_i, push_taken_i, push_target_i};

    assign w_head_target = w_head[31:0];
    assign w_head_taken  = w_head[32];
    assign w_head_idx    = w_head[33 +: IDX_W];
    assign w_head_pc     = w_head[33 + IDX_W +: 32];

    assign w_mispredict = w_do_res &&
                          bq_mispredict(w_head_taken, w_head_target, res_taken_i, res_target_i);

    branch_resolve_queue_storage #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w),
        .PTR_W (c_ptr_w)
    ) u_storage (
        .clk_i     (clk_i),
        .wr_en_i   (w_do_push && !w_mispredict),
        .wr_addr_i (r_wr_ptr),
        .wr_data_i (w_push_data),
        .rd_addr_i (r_rd_ptr),
        .rd_data_o (w_head)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_mispredict) begin
            // Flush everything younger, including a push arriving this cycle.
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_res) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + {{c_ptr_w{1'b0}}, w_do_push} - {{c_ptr_w{1'b0}}, w_do_res};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            upd_valid_o      <= 1'b0;
            upd_idx_o        <= '0;
            upd_taken_o      <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            res_err_o        <= 1'b0;
        end else begin
            upd_valid_o      <= w_do_res;
            redirect_valid_o <= w_mispredict;
            if (w_do_res) begin
                upd_idx_o   <= w_head_idx;
                upd_taken_o <= res_taken_i;
            end
            if (w_mispredict) begin
                redirect_pc_o <= res_taken_i ? res_target_i : (w_head_pc + 32'd4);
            end
            if (res_valid_i && (r_count == '0)) begin
                res_err_o <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_resolve_queue                                                  |
// | Directed self-checking bench for branch_resolve_queue.                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_branch_resolve_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        push_valid_i = 1'b0;
    logic        push_ready_o;
    logic [31:0] push_pc_i = '0;
    logic [4:0]  push_idx_i = '0;
    logic        push_taken_i = 1'b0;
    logic [31:0] push_target_i = '0;
    logic        res_valid_i = 1'b0;
    logic        res_taken_i = 1'b0;
    logic [31:0] res_target_i = '0;
    logic        upd_valid_o;
    logic [4:0]  upd_idx_o;
    logic        upd_taken_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        res_err_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  idx;
        logic        tk;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];

    always #5 clk_i = ~clk_i;

    branch_resolve_queue #(.DEPTH(4), .IDX_W(5)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .push_valid_i     (push_valid_i),
        .push_ready_o     (push_ready_o),
        .push_pc_i        (push_pc_i),
        .push_idx_i       (push_idx_i),
        .push_taken_i     (push_taken_i),
        .push_target_i    (push_target_i),
        .res_valid_i      (res_valid_i),
        .res_taken_i      (res_taken_i),
        .res_target_i     (res_target_i),
        .upd_valid_o      (upd_valid_o),
        .upd_idx_o        (upd_idx_o),
        .upd_taken_o      (upd_taken_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .res_err_o        (res_err_o)
    );

    task automatic set_push(input logic [31:0] pc, input logic [4:0] idx,
                            input logic tk, input logic [31:0] tgt);
        push_valid_i  = 1'b1;
        push_pc_i     = pc;
        push_idx_i    = idx;
        push_taken_i  = tk;
        push_target_i = tgt;
    endtask

    task automatic set_res(input logic tk, input logic [31:0] tgt);
        res_valid_i  = 1'b1;
        res_taken_i  = tk;
        res_target_i = tgt;
    endtask

    // Advance one clock, sample 1 ns after the edge, then return inputs to idle.
    task automatic step();
        @(posedge clk_i);
        #1;
        push_valid_i = 1'b0;
        res_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #3;
        n_vec++; if (upd_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_upd_valid: got %b exp 0", upd_valid_o); end
        n_vec++; if (upd_idx_o !== 5'd0) begin n_err++; $display("FAIL rst_upd_idx: got %0d exp 0", upd_idx_o); end
        n_vec++; if (upd_taken_o !== 1'b0) begin n_err++; $display("FAIL rst_upd_taken: got %b exp 0", upd_taken_o); end
        n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_redir_valid: got %b exp 0", redirect_valid_o); end
        n_vec++; if (redirect_pc_o !== 32'h0) begin n_err++; $display("FAIL rst_redir_pc: got %h exp 0", redirect_pc_o); end
        n_vec++; if (res_err_o !== 1'b0) begin n_err++; $display("FAIL rst_res_err: got %b exp 0", res_err_o); end
        n_vec++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_push_ready: got %b exp 1", push_ready_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_correct();
        set_push(32'h100, 5'd3, 1'b1, 32'h200);
        step();
        set_res(1'b1, 32'h200);
        step();
        n_vec++; if (upd_valid_o !== 1'b1) begin n_err++; $display("FAIL corr_upd_valid: got %b exp 1", upd_valid_o); end
        n_vec++; if (upd_idx_o !== 5'd3) begin n_err++; $display("FAIL corr_upd_idx: got %0d exp 3", upd_idx_o); end
        n_vec++; if (upd_taken_o !== 1'b1) begin n_err++; $display("FAIL corr_upd_taken: got %b exp 1", upd_taken_o); end
        n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL corr_redir_valid: got %b exp 0", redirect_valid_o); end
        n_vec++; if (dut.r_count !== 3'd0) begin n_err++; $display("FAIL corr_count: got %0d exp 0", dut.r_count); end
        step();
        n_vec++; if (upd_valid_o !== 1'b0) begin n_err++; $display("FAIL corr_upd_pulse: got %b exp 0", upd_valid_o); end
        n_vec++; if (upd_idx_o !== 5'd3) begin n_err++; $display("FAIL corr_upd_idx_hold: got %0d exp 3", upd_idx_o); end
    endtask

    task automatic test_mispredict_dir();
        set_push(32'h100, 5'd7, 1'b0, 32'h0);
        step();
        set_res(1'b1, 32'h180);
        step();
        n_vec++; if (redirect_valid_o !== 1'b1) begin n_err++; $display("FAIL mdir_redir_valid: got %b exp 1", redirect_valid_o); end
        n_vec++; if (redirect_pc_o !== 32'h180) begin n_err++; $display("FAIL mdir_redir_pc: got %h exp 180", redirect_pc_o); end
        n_vec++; if (upd_taken_o !== 1'b1) begin n_err++; $display("FAIL mdir_upd_taken: got %b exp 1", upd_taken_o); end
        n_vec++; if (upd_idx_o !== 5'd7) begin n_err++; $display("FAIL mdir_upd_idx: got %0d exp 7", upd_idx_o); end
        step();
        n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL mdir_redir_pulse: got %b exp 0", redirect_valid_o); end
        n_vec++; if (redirect_pc_o !== 32'h180) begin n_err++; $display("FAIL mdir_redir_hold: got %h exp 180", redirect_pc_o); end
    endtask

    task automatic test_flush();
        set_push(32'h300, 5'd4, 1'b1, 32'h400); step();
        set_push(32'h310, 5'd5, 1'b1, 32'h410); step();
        set_push(32'h320, 5'd6, 1'b0, 32'h0);   step();
        set_push(32'h330, 5'd8, 1'b1, 32'h430);
        set_res(1'b0, 32'h0);
        step();
        n_vec++; if (redirect_valid_o !== 1'b1) begin n_err++; $display("FAIL flush_redir_valid: got %b exp 1", redirect_valid_o); end
        n_vec++; if (redirect_pc_o !== 32'h304) begin n_err++; $display("FAIL flush_redir_pc: got %h exp 304", redirect_pc_o); end
        n_vec++; if (upd_taken_o !== 1'b0) begin n_err++; $display("FAIL flush_upd_taken: got %b exp 0", upd_taken_o); end
        n_vec++; if (upd_idx_o !== 5'd4) begin n_err++; $display("FAIL flush_upd_idx: got %0d exp 4", upd_idx_o); end
        n_vec++; if (dut.r_count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d exp 0", dut.r_count); end
        set_push(32'h500, 5'd9, 1'b0, 32'h0); step();
        set_res(1'b0, 32'h0); step();
        n_vec++; if (upd_idx_o !== 5'd9) begin n_err++; $display("FAIL flush_next_head: got %0d exp 9", upd_idx_o); end
        n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_next_redir: got %b exp 0", redirect_valid_o); end
        n_vec++; if (dut.r_count !== 3'd0) begin n_err++; $display("FAIL flush_next_count: got %0d exp 0", dut.r_count); end
    endtask

    task automatic test_full_wrap();
        ent_t e;
        ent_t n;
        q.delete();
        for (int k = 0; k < 4; k++) begin
            n.pc = 32'h1000 + 32'(k * 16); n.idx = 5'(k + 1); n.tk = 1'b1; n.tgt = 32'h2000 + 32'(k * 4);
            set_push(n.pc, n.idx, n.tk, n.tgt);
            step();
            q.push_back(n);
        end
        n_vec++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL full_push_ready: got %b exp 0", push_ready_o); end
        n_vec++; if (dut.r_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d exp 4", dut.r_count); end
        e = q.pop_front();
        set_push(32'hDEAD0, 5'd31, 1'b0, 32'h0);
        set_res(e.tk, e.tgt);
        #1;
        n_vec++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL full_no_bypass: got %b exp 0", push_ready_o); end
        step();
        n_vec++; if (upd_idx_o !== e.idx) begin n_err++; $display("FAIL full_drop_idx: got %0d exp %0d", upd_idx_o, e.idx); end
        n_vec++; if (dut.r_count !== 3'd3) begin n_err++; $display("FAIL full_drop_count: got %0d exp 3", dut.r_count); end
        for (int k = 4; k < 12; k++) begin
            e = q.pop_front();
            n.pc = 32'h1000 + 32'(k * 16); n.idx = 5'(k + 1); n.tk = k[0]; n.tgt = 32'h2000 + 32'(k * 4);
            set_push(n.pc, n.idx, n.tk, n.tgt);
            set_res(e.tk, e.tgt);
            step();
            q.push_back(n);
            n_vec++; if (upd_idx_o !== e.idx || upd_valid_o !== 1'b1) begin n_err++; $display("FAIL wrap_idx_%0d: got %0d/%b exp %0d/1", k, upd_idx_o, upd_valid_o, e.idx); end
            n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL wrap_redir_%0d: got %b exp 0", k, redirect_valid_o); end
            n_vec++; if (dut.r_count !== 3'd3) begin n_err++; $display("FAIL wrap_count_%0d: got %0d exp 3", k, dut.r_count); end
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            set_res(e.tk, e.tgt);
            step();
            n_vec++; if (upd_idx_o !== e.idx || upd_taken_o !== e.tk) begin n_err++; $display("FAIL drain_idx: got %0d/%b exp %0d/%b", upd_idx_o, upd_taken_o, e.idx, e.tk); end
        end
        n_vec++; if (dut.r_count !== 3'd0) begin n_err++; $display("FAIL drain_count: got %0d exp 0", dut.r_count); end
    endtask

    task automatic test_empty_err();
        set_res(1'b1, 32'h999);
        step();
        n_vec++; if (res_err_o !== 1'b1) begin n_err++; $display("FAIL err_set: got %b exp 1", res_err_o); end
        n_vec++; if (upd_valid_o !== 1'b0) begin n_err++; $display("FAIL err_no_upd: got %b exp 0", upd_valid_o); end
        n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL err_no_redir: got %b exp 0", redirect_valid_o); end
        n_vec++; if (dut.r_count !== 3'd0) begin n_err++; $display("FAIL err_count: got %0d exp 0", dut.r_count); end
        step();
        step();
        n_vec++; if (res_err_o !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b exp 1", res_err_o); end
    endtask

    task automatic test_async_reset();
        set_push(32'h700, 5'd12, 1'b1, 32'h800); step();
        set_push(32'h710, 5'd13, 1'b1, 32'h810); step();
        set_res(1'b0, 32'h0);
        #2;
        rst_i = 1'b1;
        #1;
        n_vec++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL arst_push_ready: got %b exp 1", push_ready_o); end
        n_vec++; if (res_err_o !== 1'b0) begin n_err++; $display("FAIL arst_res_err: got %b exp 0", res_err_o); end
        n_vec++; if (redirect_pc_o !== 32'h0 || upd_idx_o !== 5'd0) begin n_err++; $display("FAIL arst_outputs: got %h/%0d exp 0/0", redirect_pc_o, upd_idx_o); end
        n_vec++; if (dut.r_count !== 3'd0) begin n_err++; $display("FAIL arst_count: got %0d exp 0", dut.r_count); end
        step();
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
        n_vec++; if (upd_valid_o !== 1'b0 || redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_no_pulse: got %b/%b exp 0/0", upd_valid_o, redirect_valid_o); end
        n_vec++; if (dut.r_count !== 3'd0 || push_ready_o !== 1'b1) begin n_err++; $display("FAIL arst_after: got %0d/%b exp 0/1", dut.r_count, push_ready_o); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_correct();
        test_mispredict_dir();
        test_flush();
        test_full_wrap();
        test_empty_err();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
